// File: rtl/iq_mod_if.sv
// iq_mod_if: chip-pair handshake between the chip spreader and the I/Q modulator.
//   chip_valid : chip pair on chip_data is valid (master -> slave)
//   chip_data  : [1] = I chip, [0] = Q chip; 1 -> +1, 0 -> -1 (master -> slave)
//   chip_ready : slave can accept a chip pair this clock (slave -> master)
interface iq_mod_if;
    logic       chip_valid;
    logic [1:0] chip_data;
    logic       chip_ready;

    modport master (output chip_valid, output chip_data, input chip_ready);
    modport slave  (input chip_valid, input chip_data, output chip_ready);
endinterface

// File: rtl/iq_mod.sv
// iq_mod: O-QPSK transmit I/Q modulator.
// Takes one (I, Q) chip pair per chip period, delays Q by half a chip, mixes both
// rails with a 4-phase quadrature LO (cos = +1,0,-1,0; sin = 0,+1,0,-1) and emits
// one 2-bit signed sample per clock (01 = +1, 00 = 0, 11 = -1).
//
// Ports:
//   clk       : main clock
//   resetn    : synchronous reset, active-high
//   bus       : iq_mod_if.slave chip handshake (chip_valid/chip_data/chip_ready)
//   tx_out    : registered modulated sample, 00 while idle
//   tx_active : high while transmitting
//   underrun  : one-clock pulse when a chip boundary finds no chip buffered
//   lo_cos_out, lo_sin_out : registered LO values, only when IQ_MOD_LO_OUT_EN is defined
//
// Configuration macro: IQ_MOD_LO_OUT_EN adds the LO output ports.
module iq_mod #(
    parameter int SAMPLES_PER_PHASE = 5
) (
    input  logic       clk,
    input  logic       resetn,
    iq_mod_if.slave    bus,
    output logic [1:0] tx_out,
    output logic       tx_active,
    output logic       underrun
`ifdef IQ_MOD_LO_OUT_EN
    ,
    output logic [1:0] lo_cos_out,
    output logic [1:0] lo_sin_out
`endif
);

    localparam int CNT_W = (SAMPLES_PER_PHASE > 1) ? $clog2(SAMPLES_PER_PHASE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLES_PER_PHASE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       phase;
    logic             buf_valid, buf_i, buf_q;
    logic             i_reg, q_reg, q_next;
    logic             cnt_wrap, boundary, load_now, accept;

    function automatic logic [1:0] enc(input logic b);
        return b ? 2'b01 : 2'b11;
    endfunction

    // tx = I*cos + Q*sin, evaluated for the phase the sample will be shown in.
    function automatic logic [1:0] mix(input logic [1:0] ph, input logic i, input logic q);
        case (ph)
            2'd0:    return enc(i);
            2'd1:    return enc(q);
            2'd2:    return enc(!i);
            default: return enc(!q);
        endcase
    endfunction

`ifdef IQ_MOD_LO_OUT_EN
    function automatic logic [1:0] lo_cos(input logic [1:0] ph);
        case (ph)
            2'd0:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] lo_sin(input logic [1:0] ph);
        case (ph)
            2'd1:    return 2'b01;
            2'd3:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction
`endif

    assign cnt_wrap = (state == RUN) && (cnt == CNT_MAX);
    assign boundary = cnt_wrap && (phase == 2'd3);
    // The buffer is drained into the rails either on leaving IDLE or at a chip boundary.
    assign load_now = buf_valid && ((state == IDLE) || boundary);
    assign bus.chip_ready = !buf_valid || load_now;
    assign accept = bus.chip_valid && bus.chip_ready;

    // Outputs are computed from the values the state registers take at this edge,
    // so tx_out always matches the phase/rails currently held.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= 2'd0;
            buf_valid <= 1'b0;
            buf_i     <= 1'b0;
            buf_q     <= 1'b0;
            i_reg     <= 1'b0;
            q_reg     <= 1'b0;
            q_next    <= 1'b0;
            tx_out    <= 2'b00;
            tx_active <= 1'b0;
            underrun  <= 1'b0;
`ifdef IQ_MOD_LO_OUT_EN
            lo_cos_out <= 2'b00;
            lo_sin_out <= 2'b00;
`endif
        end else begin
            underrun <= 1'b0;

            // Accept wins over drain so a same-clock refill keeps the buffer full.
            if (accept) begin
                buf_valid <= 1'b1;
                buf_i     <= bus.chip_data[1];
                buf_q     <= bus.chip_data[0];
            end else if (load_now) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (buf_valid) begin
                        // First chip: no previous Q half-symbol, so both Q registers start aligned.
                        i_reg     <= buf_i;
                        q_reg     <= buf_q;
                        q_next    <= buf_q;
                        state     <= RUN;
                        tx_active <= 1'b1;
                        cnt       <= '0;
                        phase     <= 2'd0;
                        tx_out    <= mix(2'd0, buf_i, buf_q);
`ifdef IQ_MOD_LO_OUT_EN
                        lo_cos_out <= lo_cos(2'd0);
                        lo_sin_out <= lo_sin(2'd0);
`endif
                    end
                end
                RUN: begin
                    if (!cnt_wrap) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (phase == 2'd3) begin
                            phase <= 2'd0;
                            if (buf_valid) begin
                                // New Q waits in q_next until mid-chip (half-chip offset).
                                i_reg  <= buf_i;
                                q_next <= buf_q;
                                tx_out <= mix(2'd0, buf_i, q_reg);
`ifdef IQ_MOD_LO_OUT_EN
                                lo_cos_out <= lo_cos(2'd0);
                                lo_sin_out <= lo_sin(2'd0);
`endif
                            end else begin
                                // Underrun truncates the pending Q half-symbol.
                                state     <= IDLE;
                                tx_active <= 1'b0;
                                underrun  <= 1'b1;
                                tx_out    <= 2'b00;
`ifdef IQ_MOD_LO_OUT_EN
                                lo_cos_out <= 2'b00;
                                lo_sin_out <= 2'b00;
`endif
                            end
                        end else begin
                            phase <= phase + 2'd1;
                            if (phase == 2'd1) begin
                                q_reg  <= q_next;
                                tx_out <= mix(2'd2, i_reg, q_next);
                            end else begin
                                tx_out <= mix(phase + 2'd1, i_reg, q_reg);
                            end
`ifdef IQ_MOD_LO_OUT_EN
                            lo_cos_out <= lo_cos(phase + 2'd1);
                            lo_sin_out <= lo_sin(phase + 2'd1);
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_mod.sv
// tb_iq_mod: directed bench for iq_mod (SAMPLES_PER_PHASE = 5).
// A vector table covers idle, a single chip and a two-chip stream; hand-written
// sequences cover the continuously full buffer and a mid-chip reset.
module tb_iq_mod;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] tx_out;
    logic       tx_active;
    logic       underrun;
`ifdef IQ_MOD_LO_OUT_EN
    logic [1:0] lo_cos_out;
    logic [1:0] lo_sin_out;
`endif

    always #5 clk = ~clk;

    iq_mod_if bus ();

    iq_mod #(.SAMPLES_PER_PHASE(5)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .tx_out    (tx_out),
        .tx_active (tx_active),
        .underrun  (underrun)
`ifdef IQ_MOD_LO_OUT_EN
        ,
        .lo_cos_out(lo_cos_out),
        .lo_sin_out(lo_sin_out)
`endif
    );

    typedef struct {
        logic       vld;
        logic [1:0] data;
        logic [1:0] tx;
        logic       act;
        logic       und;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected per-phase values for chip 2'b10 (I = +1, Q = -1) and the LO.
    logic [1:0] txp[4]  = '{2'b01, 2'b11, 2'b11, 2'b01};
    logic [1:0] cosp[4] = '{2'b01, 2'b00, 2'b11, 2'b00};
    logic [1:0] sinp[4] = '{2'b00, 2'b01, 2'b00, 2'b11};

    task automatic add(input int n, input logic v, input logic [1:0] d,
                       input logic [1:0] tx, input logic a, input logic u, input logic r);
        repeat (n) vecs.push_back('{vld: v, data: d, tx: tx, act: a, und: u, rdy: r});
    endtask

    task automatic chk2(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
        end
    endtask

    initial begin
        resetn         = 1'b1;
        bus.chip_valid = 1'b0;
        bus.chip_data  = 2'b00;
        repeat (3) @(negedge clk);
        chk2("rst_tx", tx_out, 2'b00);
        chk1("rst_active", tx_active, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        chk1("rst_ready", bus.chip_ready, 1'b1);
        resetn = 1'b0;

        // Idle for 100 clocks.
        add(100, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        // Single chip 11: +1 x10, -1 x10, then underrun.
        add(1,  1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        add(1,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        add(10, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1);
        add(10, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
        add(1,  1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        add(3,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        // Stream 11 then 00; second chip accepted while the first is loaded.
        add(1,  1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        add(1,  1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        add(10, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        add(9,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
        add(1,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
        // Second chip: -I, old Q (+1), -I (+1), -new Q (+1).
        add(5,  1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1);
        add(15, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1);
        add(1,  1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        add(2,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        foreach (vecs[k]) begin
            @(negedge clk);
            chk2("vec_tx", tx_out, vecs[k].tx);
            chk1("vec_active", tx_active, vecs[k].act);
            chk1("vec_underrun", underrun, vecs[k].und);
            chk1("vec_ready", bus.chip_ready, vecs[k].rdy);
            bus.chip_valid = vecs[k].vld;
            bus.chip_data  = vecs[k].data;
        end

        // Continuously valid chip 10: one chip per 20 clocks, ready only at boundaries.
        bus.chip_valid = 1'b1;
        bus.chip_data  = 2'b10;
        @(negedge clk);
        chk2("full_first_tx", tx_out, 2'b00);
        chk1("full_first_ready", bus.chip_ready, 1'b1);
        for (int k = 2; k <= 54; k++) begin
            int pos;
            int ph;
            @(negedge clk);
            pos = (k - 2) % 20;
            ph  = pos / 5;
            chk2("full_tx", tx_out, txp[ph]);
            chk1("full_active", tx_active, 1'b1);
            chk1("full_underrun", underrun, 1'b0);
            chk1("full_ready", bus.chip_ready, pos == 19);
`ifdef IQ_MOD_LO_OUT_EN
            chk2("lo_cos", lo_cos_out, cosp[ph]);
            chk2("lo_sin", lo_sin_out, sinp[ph]);
`endif
        end

        // Reset in phase 2 with the buffer full.
        resetn         = 1'b1;
        bus.chip_valid = 1'b0;
        bus.chip_data  = 2'b00;
        @(negedge clk);
        chk2("rst_mid_tx", tx_out, 2'b00);
        chk1("rst_mid_active", tx_active, 1'b0);
        chk1("rst_mid_ready", bus.chip_ready, 1'b1);
        chk1("rst_mid_underrun", underrun, 1'b0);
        resetn = 1'b0;
        repeat (30) begin
            @(negedge clk);
            chk2("post_rst_tx", tx_out, 2'b00);
            chk1("post_rst_active", tx_active, 1'b0);
            chk1("post_rst_underrun", underrun, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
